pedal_sig_filt: RTL and testbench
=================================

// Module: pedal_sig_filt
// PURPOSE
//  N-channel glitch filter and edge/period extractor for slow mechanical eBike
//  inputs (cadence, brake lever, mode buttons). Each channel is synchronised,
//  debounced by a stability counter, and edge-detected. Each channel also
//  measures the clock count between filtered rising edges (cadence period).
//  Sits between the input pins and the torque/cadence consumers.
// PARAMETERS
//  N_CH      2       number of independent channels (1..8)
//  FAST_SIM  0       1 = use STBL_FAST threshold (simulation), 0 = STBL_FULL
//  STBL_FULL 65535   consecutive stable clocks required, silicon (<= 2**CNT_W-1)
//  STBL_FAST 511     consecutive stable clocks required, FAST_SIM
//  CNT_W     16      stability counter width
//  PER_W     24      period counter width
// PORTS
//  clk         in   1            system clock
//  rst_n       in   1            asynchronous active-low reset
//  sig_in      in   N_CH         raw asynchronous inputs
//  sig_filt    out  N_CH         debounced level
//  sig_rise    out  N_CH         1-clk pulse, filtered rising edge
//  sig_fall    out  N_CH         1-clk pulse, filtered falling edge
//  period      out  N_CH*PER_W   last rise-to-rise clock count, ch i at [i*PER_W +: PER_W]
//  period_vld  out  N_CH         1-clk pulse when period[i] is updated
//  stalled     out  N_CH         period counter saturated, no rise seen
// BEHAVIOUR
//  - Reset (async): all flops 0. sig_filt, sig_rise, sig_fall, period, period_vld,
//    stalled = 0. Each channel enters UNARMED.
//  - Sync: two flops (s1, s2), then delay flop s3. chg = s2 ^ s3.
//  - Stability: cnt <= chg ? 0 : sat_inc(cnt). Saturates at all-ones and never wraps.
//    Let STBL = FAST_SIM ? STBL_FAST : STBL_FULL.
//    sig_filt <= s3 when cnt >= STBL and !chg.
//  - Latency: a pin level held constant reaches sig_filt exactly STBL+3 clks after
//    the first clk edge that samples it. A pulse shorter than STBL+1 clks is never
//    passed.
//  - Edges: registered filt_d. sig_rise = filt & ~filt_d. sig_fall = ~filt & filt_d.
//    Each asserts during the first cycle of the new level. At most one is asserted
//    per cycle.
//  - Period state machine (per channel):
//    UNARMED -rise-> RUN. This sets pcnt = 1 and produces no period_vld.
//    RUN: pcnt <= sat_inc(pcnt) each clk.
//    On rise: period <= pcnt, period_vld = 1 in the same cycle as sig_rise, pcnt <= 1.
//    pcnt reaching all-ones sets stalled = 1. Stay in RUN.
//    A rise while stalled latches period = all-ones and clears stalled.
//  - period holds its value between updates. Channels are fully independent, and
//    simultaneous events on different channels are all reported in the same cycle.
//  - Reset mid-operation returns every channel to UNARMED, with outputs 0
//    immediately (async).
//  - period and stalled are not reset by falling edges.
// STRUCTURE
//  - Shared package eBike_pkg:
//    localparam STBL_FULL_DEF = 65535, STBL_FAST_DEF = 511.
//    typedef enum logic {UNARMED, RUN} per_state_t.
//  - One sub-module, pedal_filt_chan: one channel (sync, stability, edges, period).
//    Top = generate loop of N_CH instances with bus packing.
// TESTING (FAST_SIM=1, STBL=511, N_CH=2, PER_W=24)
//  - Reset: assert rst_n=0 mid-run -> all outputs 0 same cycle. After release,
//    rise without period_vld.
//  - Glitch: ch0 high for 300 clks then low -> sig_filt[0] stays 0, no sig_rise.
//  - Step: ch0 0->1 held -> sig_filt[0] = 1 exactly 514 clks later.
//    sig_rise[0] pulses 1 clk. Later 1->0 -> sig_fall[0] after 514 clks.
//  - Period: ch1 square wave, 2000-clk period, 1000 high -> 2nd+ rises give
//    period[1] = 2000 with period_vld[1] coincident with sig_rise[1].
//  - Stall: PER_W=12, ch0 rises then idles 5000 clks -> stalled[0] = 1 at
//    pcnt=4095. Next rise -> period = 4095, stalled cleared.
//  - Independence: both channels step on the same clk -> identical sig_rise
//    timing on ch0 and ch1.

Source files
------------

// File: rtl/eBike_pkg.sv
// eBike_pkg: shared constants and types for the eBike input conditioning blocks
package eBike_pkg;
  localparam int STBL_FULL_DEF = 65535;
  localparam int STBL_FAST_DEF = 511;
  typedef enum logic {UNARMED, RUN} per_state_t;
endpackage

// File: rtl/pedal_filt_chan.sv
// pedal_filt_chan: one channel of sync, stability debounce, edge detect and rise-to-rise period
module pedal_filt_chan
  import eBike_pkg::*;
#(
  parameter int FAST_SIM  = 0,
  parameter int STBL_FULL = STBL_FULL_DEF,
  parameter int STBL_FAST = STBL_FAST_DEF,
  parameter int CNT_W     = 16,
  parameter int PER_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             sig_filt,
  output logic             sig_rise,
  output logic             sig_fall,
  output logic [PER_W-1:0] period,
  output logic             period_vld,
  output logic             stalled
);
  localparam logic [CNT_W-1:0] STBL = CNT_W'(FAST_SIM != 0 ? STBL_FAST : STBL_FULL);
  logic s1, s2, s3, chg, filt_nxt, rise_nxt, fall_nxt, per_upd;
  logic [CNT_W-1:0] cnt;
  logic [PER_W-1:0] pcnt;
  per_state_t state, state_nxt;
  always_comb begin
    chg = s2 ^ s3;
    filt_nxt = (cnt >= STBL && !chg) ? s3 : sig_filt;
    rise_nxt = filt_nxt & ~sig_filt;
    fall_nxt = ~filt_nxt & sig_filt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= UNARMED;
    else state <= state_nxt;
  always_comb state_nxt = rise_nxt ? RUN : state;
  always_comb per_upd = rise_nxt && state == RUN;
  // pcnt is held at zero while unarmed, so all-ones can only mean a stalled RUN
  assign stalled = &pcnt;
  // edge pulses and period are registered together so period is valid with period_vld
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
      sig_filt <= 1'b0;
      sig_rise <= 1'b0;
      sig_fall <= 1'b0;
      period <= '0;
      period_vld <= 1'b0;
      pcnt <= '0;
    end else begin
      {s1, s2, s3} <= {sig_in, s1, s2};
      cnt <= chg ? '0 : cnt + CNT_W'(~&cnt);
      sig_filt <= filt_nxt;
      sig_rise <= rise_nxt;
      sig_fall <= fall_nxt;
      period_vld <= per_upd;
      if (per_upd) period <= pcnt;
      pcnt <= rise_nxt ? PER_W'(1) : (state == RUN ? pcnt + PER_W'(~&pcnt) : '0);
    end
endmodule

// File: rtl/pedal_sig_filt.sv
// pedal_sig_filt: N-channel glitch filter with edge pulses and cadence period measurement
module pedal_sig_filt
  import eBike_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int FAST_SIM  = 0,
  parameter int STBL_FULL = STBL_FULL_DEF,
  parameter int STBL_FAST = STBL_FAST_DEF,
  parameter int CNT_W     = 16,
  parameter int PER_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       sig_in,
  output logic [N_CH-1:0]       sig_filt,
  output logic [N_CH-1:0]       sig_rise,
  output logic [N_CH-1:0]       sig_fall,
  output logic [N_CH*PER_W-1:0] period,
  output logic [N_CH-1:0]       period_vld,
  output logic [N_CH-1:0]       stalled
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pedal_filt_chan #(
      .FAST_SIM (FAST_SIM),
      .STBL_FULL(STBL_FULL),
      .STBL_FAST(STBL_FAST),
      .CNT_W    (CNT_W),
      .PER_W    (PER_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_in    (sig_in[i]),
      .sig_filt  (sig_filt[i]),
      .sig_rise  (sig_rise[i]),
      .sig_fall  (sig_fall[i]),
      .period    (period[i*PER_W +: PER_W]),
      .period_vld(period_vld[i]),
      .stalled   (stalled[i])
    );
  end
endmodule

// File: tb/tb_pedal_sig_filt.sv
// tb_pedal_sig_filt: directed and random checks of pedal_sig_filt against a run-length reference model
module tb_pedal_sig_filt;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] sig = '0;
  logic [1:0] filt_a, rise_a, fall_a, vld_a, stl_a, filt_b, rise_b, fall_b, vld_b, stl_b;
  logic [47:0] per_a;
  logic [23:0] per_b;
  logic [63:0] obs_a, obs_b;
  int errors = 0, checks = 0, lat, nv;
  logic seen, r1;
  int rem [2];
  // reference model: pin run lengths, filtered levels, rise times per instance
  longint k;
  int run [2];
  bit [1:0] last, q1ok, q1v, q2ok, q2v, mf, mr, mfl;
  bit [1:0] armed [2], mvld [2], mstl [2];
  longint lastr [2][2];
  logic [23:0] per_m [2][2];
  longint maxv [2] = '{64'd16777215, 64'd4095};

  always #5 clk = ~clk;

  pedal_sig_filt #(.N_CH(2), .FAST_SIM(1), .PER_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig), .sig_filt(filt_a), .sig_rise(rise_a),
    .sig_fall(fall_a), .period(per_a), .period_vld(vld_a), .stalled(stl_a));
  pedal_sig_filt #(.N_CH(2), .FAST_SIM(1), .PER_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig), .sig_filt(filt_b), .sig_rise(rise_b),
    .sig_fall(fall_b), .period(per_b), .period_vld(vld_b), .stalled(stl_b));

  assign obs_a = {6'd0, filt_a, rise_a, fall_a, vld_a, stl_a, per_a};
  assign obs_b = {30'd0, filt_b, rise_b, fall_b, vld_b, stl_b, per_b};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; last = '0; q1ok = '0; q1v = '0; q2ok = '0; q2v = '0; mf = '0; mr = '0; mfl = '0;
    for (int d = 0; d < 2; d++) begin
      armed[d] = '0; mvld[d] = '0; mstl[d] = '0;
      for (int c = 0; c < 2; c++) begin
        run[c] = 0; lastr[d][c] = 0; per_m[d][c] = '0;
      end
    end
  endtask

  // one clock: sample pins, advance the model, then compare both instances after the edge
  task automatic tick();
    logic [1:0] x;
    logic nf;
    longint p;
    x = sig;
    @(posedge clk);
    k++;
    for (int c = 0; c < 2; c++) begin
      run[c] = (x[c] == last[c]) ? run[c] + 1 : 1;
      last[c] = x[c];
      // a level is accepted once it has been seen on 513 consecutive samples, two clocks later
      nf = q2ok[c] ? q2v[c] : mf[c];
      q2ok[c] = q1ok[c]; q2v[c] = q1v[c];
      q1ok[c] = run[c] >= 513; q1v[c] = x[c];
      mr[c] = nf & ~mf[c];
      mfl[c] = ~nf & mf[c];
      mf[c] = nf;
      for (int d = 0; d < 2; d++) begin
        mvld[d][c] = 1'b0;
        if (mr[c]) begin
          if (armed[d][c]) begin
            p = k - lastr[d][c];
            per_m[d][c] = 24'(p > maxv[d] ? maxv[d] : p);
            mvld[d][c] = 1'b1;
          end
          armed[d][c] = 1'b1;
          lastr[d][c] = k;
        end
        mstl[d][c] = armed[d][c] && (1 + k - lastr[d][c]) >= maxv[d];
      end
    end
    #1;
    chk("cyc24", obs_a, {6'd0, mf, mr, mfl, mvld[0], mstl[0], per_m[0][1], per_m[0][0]});
    chk("cyc12", obs_b, {30'd0, mf, mr, mfl, mvld[1], mstl[1], per_m[1][1][11:0], per_m[1][0][11:0]});
  endtask

  // which: 0 = rise_a[0], 1 = fall_a[0], 2 = vld_b[0]; lat stays -1 if the bound expires
  task automatic wait_for(input int which, output int n);
    n = -1;
    for (int i = 0; i < 700; i++) begin
      tick();
      if ((which == 0 && rise_a[0]) || (which == 1 && fall_a[0]) || (which == 2 && vld_b[0])) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    model_reset();
    #22 rst_n = 1'b1;
    chk("reset24", obs_a, 64'd0);
    chk("reset12", obs_b, 64'd0);
    // glitch shorter than the threshold never passes
    seen = 1'b0;
    sig[0] = 1'b1;
    repeat (300) begin tick(); seen |= rise_a[0]; end
    sig[0] = 1'b0;
    repeat (600) begin tick(); seen |= rise_a[0]; end
    chk("glitch_rise", 64'(seen), 64'd0);
    chk("glitch_filt", 64'(filt_a[0]), 64'd0);
    // simultaneous step on both channels
    sig = 2'b11;
    wait_for(0, lat);
    r1 = rise_a[1];
    chk("step_lat", 64'(lat), 64'd514);
    chk("indep_rise", 64'(r1), 64'd1);
    chk("step_filt", 64'(filt_a[0]), 64'd1);
    tick();
    chk("rise_1clk", 64'(rise_a[0]), 64'd0);
    sig = 2'b00;
    wait_for(1, lat);
    chk("fall_lat", 64'(lat), 64'd514);
    // 2000-clock square wave on ch1
    nv = 0;
    for (int h = 0; h < 10; h++) begin
      sig[1] = ~sig[1];
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (vld_a[1]) begin
          nv++;
          if (nv > 1) begin
            chk("per2000", 64'(per_a[47:24]), 64'd2000);
            chk("vld_rise", 64'(rise_a[1]), 64'd1);
          end
        end
      end
    end
    chk("per_count", 64'(nv), 64'd5);
    // stall on the 12-bit instance
    sig[0] = 1'b1;
    repeat (5000) tick();
    chk("stall12", 64'(stl_b[0]), 64'd1);
    chk("nostall24", 64'(stl_a[0]), 64'd0);
    sig[0] = 1'b0;
    repeat (600) tick();
    sig[0] = 1'b1;
    wait_for(2, lat);
    chk("stall_seen", 64'(lat >= 0), 64'd1);
    chk("stall_per", 64'(per_b[11:0]), 64'd4095);
    chk("stall_clr", 64'(stl_b[0]), 64'd0);
    // asynchronous reset mid-run
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid24", obs_a, 64'd0);
    chk("rst_mid12", obs_b, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_for(0, lat);
    chk("rst_lat", 64'(lat), 64'd514);
    chk("rst_novld", 64'(vld_a[0]), 64'd0);
    // random pin activity on both channels
    rem[0] = 0; rem[1] = 0;
    for (int i = 0; i < 12000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          sig[c] = 1'($urandom_range(0, 1));
          rem[c] = $urandom_range(50, 1500);
        end
        rem[c]--;
      end
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
